dx_bypass_pipe: RTL and testbench
=================================

Name: dx_bypass_pipe

Overview:
- Parametrised decode-to-execute pipeline register with an integrated operand bypass network.
- Holds one decoded instruction. Resolves each of NSRC source operands against NFWD downstream writer stages, youngest first.
- Stalls on a match whose data is not ready yet, such as a load in flight. Issues the resolved instruction into a registered X-stage output with a valid/ready handshake.
- Sits between the register-file read and the execute stage, replacing the combinational-only bypass plus external bubble muxing.

Parameters:
- XLEN, 32, data width of operands and forwarded values
- NSRC, 2, number of source operands per instruction
- NFWD, 3, number of writer stages checked; index 0 is youngest (X), then M, then W
- RA_W, 5, register address width; address 0 is hardwired zero
- PAYLOAD_W, 64, opaque passthrough width (ctrl, pc, imm bundle)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of held entry and output register
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  block accepts this cycle
- in_src_addr  in  NSRC*RA_W  source register addresses
- in_src_data  in  NSRC*XLEN  register-file read data
- in_dst_addr  in  RA_W  destination address, passed through
- in_wr_en  in  1  instruction writes dst, passed through
- in_payload  in  PAYLOAD_W  passthrough bundle
- stg_wr_en  in  NFWD  stage k will write a register
- stg_addr  in  NFWD*RA_W  stage k destination
- stg_data  in  NFWD*XLEN  stage k result
- stg_data_ok  in  NFWD  stage k result is valid now; 0 means a load is pending
- out_valid  out  1  X-stage register holds an issued instruction
- out_ready  in  1  execute consumes
- out_src_data  out  NSRC*XLEN  resolved operands
- out_dst_addr  out  RA_W
- out_wr_en  out  1
- out_payload  out  PAYLOAD_W
- stall  out  1  hazard holding the entry this cycle

Behaviour:
- Reset: entry_valid=0, out_valid=0, and all output data/addr/payload registers are 0. Consequently in_ready=1 and stall=0.
- Entry (D) register: captures in_* when in_valid && in_ready. in_ready = !entry_valid || issue.
- Operand resolve, per source s, evaluated on the held entry each cycle:
  - If addr==0, the operand is 0.
  - Otherwise find the lowest k with stg_wr_en[k] && stg_addr[k]==addr.
  - If found and stg_data_ok[k], the operand is stg_data[k].
  - If found and !stg_data_ok[k], the source is a hazard.
  - If none is found, the operand is the captured register-file value.
  - A pending younger match is never bypassed by an older ready match.
- stall = entry_valid && any source hazard.
- issue = entry_valid && !stall && (!out_valid || out_ready).
- On issue, the X register loads the resolved operands and the passthroughs, and sets out_valid=1. Latency is 1 cycle from acceptance with no hazard and no backpressure.
- If out_valid && out_ready && !issue, out_valid clears. A bubble is inserted, never a duplicate.
- A stalled entry re-evaluates every cycle. Captured register-file data is not refreshed; writers are covered by the stage inputs.
- Simultaneous accept and issue in the same cycle is legal (full throughput).
- flush clears entry_valid and out_valid next edge. It has priority over accept and issue, and in_ready=0 during flush.
- Asynchronous reset asserted mid-stall drops everything immediately.
- Out registers hold their value while out_valid && !out_ready.

Optional Feature:
- Macro DX_BYPASS_STATS_EN.
- When defined, adds three outputs:
  - stall_cycles (32 bit, saturating): increments each cycle stall=1.
  - fwd_count (32 bit, saturating): increments by the number of sources taken from a stage on each issue.
  - stats_clr (input, 1 bit): synchronously zeroes both counters.
  - Both counters reset to 0.
- When undefined, these ports and counters are absent and the behaviour is identical otherwise.

Decomposition:
- Package definitions adds:
  - fwd_stage_t struct {wr_en, addr, data, data_ok}.
  - dx_entry_t struct {src_addr[NSRC], src_data[NSRC], dst_addr, wr_en, payload}.
  - REG_ZERO constant.
- One sub-module, dx_operand_resolve: combinational per-source priority match returning {data, hazard}. It is instantiated NSRC times.

Test Plan:
- No hazard:
  - Stimulus: accept src=(3,4), rf=(0x11,0x22), no stages writing.
  - Required: next cycle out_valid=1, out_src_data=(0x11,0x22).
- Priority:
  - Stimulus: stage0 and stage2 both write r3 (0xAA, 0xCC), both data_ok.
  - Required: src0 resolves to 0xAA. Same with stage0 data_ok=0 gives stall=1, out_valid=0, in_ready=0.
- Load-use:
  - Stimulus: stage0 writes r4 with data_ok=0 for 2 cycles, then data_ok=1 with 0x55.
  - Required: stall=1 for 2 cycles, then issue with src1=0x55. Exactly one out_valid pulse.
- r0 and backpressure:
  - Stimulus: src0=0 while a stage writes r0=0xFF; then hold out_ready=0 for 3 cycles.
  - Required: operand is 0; outputs stable; in_ready=0 once the entry is full.
- Flush / reset:
  - Stimulus: flush while stalled and out_valid=1; separately drop rst_n mid-operation.
  - Required: next cycle entry and out are empty. Reset clears them immediately and asynchronously.
- With DX_BYPASS_STATS_EN:
  - Stimulus: the load-use scenario.
  - Required: stall_cycles=2, fwd_count=1. stats_clr zeroes both.

Source files
------------

// File: rtl/dx_bypass_pipe_pkg.sv
// Shared types and constants for the decode-to-execute bypass pipe.
// Optional statistics counters are enabled with DX_BYPASS_STATS_EN.
package dx_bypass_pipe_pkg;

  localparam int DX_XLEN      = 32;
  localparam int DX_NSRC      = 2;
  localparam int DX_NFWD      = 3;
  localparam int DX_RA_W      = 5;
  localparam int DX_PAYLOAD_W = 64;

  localparam logic [DX_RA_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic               wr_en;
    logic [DX_RA_W-1:0] addr;
    logic [DX_XLEN-1:0] data;
    logic               data_ok;
  } fwd_stage_t;

  typedef struct packed {
    logic [DX_NSRC-1:0][DX_RA_W-1:0] src_addr;
    logic [DX_NSRC-1:0][DX_XLEN-1:0] src_data;
    logic [DX_RA_W-1:0]              dst_addr;
    logic                            wr_en;
    logic [DX_PAYLOAD_W-1:0]         payload;
  } dx_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/dx_bypass_pipe_if.sv
// Decode-side, writer-stage and execute-side signals of dx_bypass_pipe.
// master drives instructions/stages/consumer ready; slave is the pipe.
interface dx_bypass_pipe_if import dx_bypass_pipe_pkg::*; #(
  parameter int XLEN      = DX_XLEN,
  parameter int NSRC      = DX_NSRC,
  parameter int NFWD      = DX_NFWD,
  parameter int RA_W      = DX_RA_W,
  parameter int PAYLOAD_W = DX_PAYLOAD_W
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [NSRC-1:0][RA_W-1:0]  in_src_addr;
  logic [NSRC-1:0][XLEN-1:0]  in_src_data;
  logic [RA_W-1:0]            in_dst_addr;
  logic                       in_wr_en;
  logic [PAYLOAD_W-1:0]       in_payload;
  logic [NFWD-1:0]            stg_wr_en;
  logic [NFWD-1:0][RA_W-1:0]  stg_addr;
  logic [NFWD-1:0][XLEN-1:0]  stg_data;
  logic [NFWD-1:0]            stg_data_ok;
  logic                       out_valid;
  logic                       out_ready;
  logic [NSRC-1:0][XLEN-1:0]  out_src_data;
  logic [RA_W-1:0]            out_dst_addr;
  logic                       out_wr_en;
  logic [PAYLOAD_W-1:0]       out_payload;
  logic                       stall;

  modport master (
    output flush, in_valid, in_src_addr, in_src_data, in_dst_addr, in_wr_en, in_payload,
           stg_wr_en, stg_addr, stg_data, stg_data_ok, out_ready,
    input  in_ready, out_valid, out_src_data, out_dst_addr, out_wr_en, out_payload, stall
  );

  modport slave (
    input  flush, in_valid, in_src_addr, in_src_data, in_dst_addr, in_wr_en, in_payload,
           stg_wr_en, stg_addr, stg_data, stg_data_ok, out_ready,
    output in_ready, out_valid, out_src_data, out_dst_addr, out_wr_en, out_payload, stall
  );
endinterface

// File: rtl/dx_operand_resolve.sv
// One source operand against all writer stages; the youngest matching stage wins.
// With DX_BYPASS_STATS_EN, fwd flags an operand taken from a stage.
module dx_operand_resolve import dx_bypass_pipe_pkg::*; #(
  parameter int NFWD = DX_NFWD
) (
  input  logic [DX_RA_W-1:0]    addr,
  input  logic [DX_XLEN-1:0]    rf_data,
  input  fwd_stage_t [NFWD-1:0] stg,
  output logic [DX_XLEN-1:0]    data,
  output logic                  hazard
`ifdef DX_BYPASS_STATS_EN
  ,
  output logic                  fwd
`endif
);

  logic hit;

  // Once the youngest match is found, older stages are ignored even if ready.
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    hit    = 1'b0;
    if (addr == REG_ZERO) begin
      data = '0;
    end else begin
      for (int k = 0; k < NFWD; k++) begin
        if (!hit && stg[k].wr_en && stg[k].addr == addr) begin
          hit = 1'b1;
          if (stg[k].data_ok) data = stg[k].data;
          else                hazard = 1'b1;
        end
      end
    end
  end

`ifdef DX_BYPASS_STATS_EN
  assign fwd = hit && !hazard;
`endif

endmodule

// File: rtl/dx_bypass_pipe.sv
// D-stage entry register with operand bypass and a registered X-stage output.
// DX_BYPASS_STATS_EN adds stall_cycles/fwd_count counters and stats_clr.
module dx_bypass_pipe import dx_bypass_pipe_pkg::*; #(
  parameter int XLEN      = DX_XLEN,
  parameter int NSRC      = DX_NSRC,
  parameter int NFWD      = DX_NFWD,
  parameter int RA_W      = DX_RA_W,
  parameter int PAYLOAD_W = DX_PAYLOAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  dx_bypass_pipe_if.slave   bus
`ifdef DX_BYPASS_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       fwd_count
`endif
);

  dx_entry_t                 entry_q, entry_d;
  logic                      entry_valid_q, entry_valid_d;
  logic                      out_valid_q, out_valid_d;
  logic [NSRC-1:0][XLEN-1:0] out_src_data_q, out_src_data_d;
  logic [RA_W-1:0]           out_dst_addr_q, out_dst_addr_d;
  logic                      out_wr_en_q, out_wr_en_d;
  logic [PAYLOAD_W-1:0]      out_payload_q, out_payload_d;

  fwd_stage_t [NFWD-1:0]     stg;
  logic [NSRC-1:0][XLEN-1:0] res_data;
  logic [NSRC-1:0]           hazard;
  logic                      stall, issue, in_ready, accept;
`ifdef DX_BYPASS_STATS_EN
  logic [NSRC-1:0]           fwd_hit;
`endif

  for (genvar k = 0; k < NFWD; k++) begin : g_stg
    assign stg[k] = '{wr_en: bus.stg_wr_en[k], addr: bus.stg_addr[k],
                      data: bus.stg_data[k], data_ok: bus.stg_data_ok[k]};
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    dx_operand_resolve #(.NFWD(NFWD)) u_res (
      .addr    (entry_q.src_addr[s]),
      .rf_data (entry_q.src_data[s]),
      .stg     (stg),
      .data    (res_data[s]),
      .hazard  (hazard[s])
`ifdef DX_BYPASS_STATS_EN
      ,
      .fwd     (fwd_hit[s])
`endif
    );
  end

  // Flush outranks issue and accept, so it is folded into both strobes.
  assign stall    = entry_valid_q && |hazard;
  assign issue    = entry_valid_q && !stall && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign in_ready = !bus.flush && (!entry_valid_q || issue);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    entry_d       = entry_q;
    entry_valid_d = entry_valid_q;
    if (bus.flush) begin
      entry_valid_d = 1'b0;
    end else begin
      if (issue) entry_valid_d = 1'b0;
      if (accept) begin
        entry_valid_d = 1'b1;
        entry_d = '{src_addr: bus.in_src_addr, src_data: bus.in_src_data,
                    dst_addr: bus.in_dst_addr, wr_en: bus.in_wr_en, payload: bus.in_payload};
      end
    end
  end

  // Data registers only move on issue, so a stalled consumer sees stable values.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_src_data_d = out_src_data_q;
    out_dst_addr_d = out_dst_addr_q;
    out_wr_en_d    = out_wr_en_q;
    out_payload_d  = out_payload_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d    = 1'b1;
      out_src_data_d = res_data;
      out_dst_addr_d = entry_q.dst_addr;
      out_wr_en_d    = entry_q.wr_en;
      out_payload_d  = entry_q.payload;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q        <= '0;
      entry_valid_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_src_data_q <= '0;
      out_dst_addr_q <= '0;
      out_wr_en_q    <= 1'b0;
      out_payload_q  <= '0;
    end else begin
      entry_q        <= entry_d;
      entry_valid_q  <= entry_valid_d;
      out_valid_q    <= out_valid_d;
      out_src_data_q <= out_src_data_d;
      out_dst_addr_q <= out_dst_addr_d;
      out_wr_en_q    <= out_wr_en_d;
      out_payload_q  <= out_payload_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.stall        = stall;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_src_data = out_src_data_q;
  assign bus.out_dst_addr = out_dst_addr_q;
  assign bus.out_wr_en    = out_wr_en_q;
  assign bus.out_payload  = out_payload_q;

`ifdef DX_BYPASS_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_count_q, fwd_count_d;
  logic [31:0] fwd_n;

  always_comb begin
    fwd_n = '0;
    for (int s = 0; s < NSRC; s++) fwd_n = fwd_n + 32'(fwd_hit[s]);
    stall_cycles_d = stall_cycles_q;
    fwd_count_d    = fwd_count_q;
    if (stats_clr) begin
      stall_cycles_d = '0;
      fwd_count_d    = '0;
    end else begin
      if (stall) stall_cycles_d = sat_add32(stall_cycles_q, 32'd1);
      if (issue) fwd_count_d    = sat_add32(fwd_count_q, fwd_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_count_q    <= fwd_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`endif

endmodule

// File: tb/tb_dx_bypass_pipe.sv
// Directed scenarios plus randomized traffic for dx_bypass_pipe, checked by a
// transaction-level model feeding an output scoreboard.
module tb_dx_bypass_pipe;
  import dx_bypass_pipe_pkg::*;

  localparam int XL = DX_XLEN, NS = DX_NSRC, NF = DX_NFWD, RW = DX_RA_W, PW = DX_PAYLOAD_W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dx_bypass_pipe_if bus();
`ifdef DX_BYPASS_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] stall_cycles, fwd_count;
`endif

  dx_bypass_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DX_BYPASS_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .stall_cycles (stall_cycles),
    .fwd_count    (fwd_count)
`endif
  );

  typedef struct {
    logic [NS-1:0][RW-1:0] a;
    logic [NS-1:0][XL-1:0] rf;
    logic [RW-1:0]         dst;
    logic                  wr;
    logic [PW-1:0]         pl;
  } ins_t;

  typedef struct {
    logic [NS-1:0][XL-1:0] d;
    logic [RW-1:0]         dst;
    logic                  wr;
    logic [PW-1:0]         pl;
  } out_t;

  // next-cycle stimulus
  bit                    n_flush, n_in_valid, n_wr, n_out_ready, n_stats_clr;
  logic [NS-1:0][RW-1:0] n_src_addr;
  logic [NS-1:0][XL-1:0] n_src_data;
  logic [RW-1:0]         n_dst;
  logic [PW-1:0]         n_pl;
  logic [NF-1:0]         n_stg_wr, n_stg_ok;
  logic [NF-1:0][RW-1:0] n_stg_addr;
  logic [NF-1:0][XL-1:0] n_stg_data;

  // reference model state
  ins_t m_ent;
  bit   m_ent_v, m_x_v;
  out_t q[$];
  bit   e_stall, e_in_ready, e_out_valid;
  int   m_stall_cnt, m_fwd_cnt;
  bit   mon_en;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Operand value per the forwarding rules, using the stage inputs of this cycle.
  function automatic void resolve(input logic [RW-1:0] a, input logic [XL-1:0] rf,
                                  output logic [XL-1:0] v, output bit hz, output bit fw);
    v = rf; hz = 0; fw = 0;
    if (a == 0) begin v = '0; return; end
    for (int k = 0; k < NF; k++) begin
      if (n_stg_wr[k] && n_stg_addr[k] == a) begin
        if (n_stg_ok[k]) begin v = n_stg_data[k]; fw = 1; end
        else hz = 1;
        return;
      end
    end
  endfunction

  task automatic idle();
    n_flush = 0; n_in_valid = 0; n_out_ready = 1; n_stats_clr = 0;
    n_stg_wr = '0; n_stg_ok = '1; n_stg_addr = '0; n_stg_data = '0;
  endtask

  task automatic offer(input int a0, input int a1, input logic [XL-1:0] d0, input logic [XL-1:0] d1);
    n_in_valid = 1;
    n_src_addr[0] = RW'(a0); n_src_addr[1] = RW'(a1);
    n_src_data[0] = d0;      n_src_data[1] = d1;
    n_dst = RW'($urandom_range(0, 31)); n_wr = 1'($urandom_range(0, 1));
    n_pl = {$urandom, $urandom};
  endtask

  task automatic apply();
    bus.flush = n_flush; bus.in_valid = n_in_valid; bus.in_src_addr = n_src_addr;
    bus.in_src_data = n_src_data; bus.in_dst_addr = n_dst; bus.in_wr_en = n_wr;
    bus.in_payload = n_pl; bus.stg_wr_en = n_stg_wr; bus.stg_addr = n_stg_addr;
    bus.stg_data = n_stg_data; bus.stg_data_ok = n_stg_ok; bus.out_ready = n_out_ready;
`ifdef DX_BYPASS_STATS_EN
    stats_clr = n_stats_clr;
`endif
  endtask

  // One cycle: drive stimulus, then advance the model by the coming edge.
  task automatic step();
    out_t o;
    bit hz, fw, hz_any, consumed, issue;
    int nf;
    logic [XL-1:0] v;
    @(posedge clk); #1;
    apply();
    hz_any = 0; nf = 0;
    o.dst = m_ent.dst; o.wr = m_ent.wr; o.pl = m_ent.pl;
    for (int s = 0; s < NS; s++) begin
      resolve(m_ent.a[s], m_ent.rf[s], v, hz, fw);
      o.d[s] = v;
      if (hz) hz_any = 1;
      if (fw) nf++;
    end
    e_stall     = m_ent_v && hz_any;
    e_out_valid = m_x_v;
    consumed    = m_x_v && n_out_ready;
    issue       = m_ent_v && !hz_any && (!m_x_v || consumed) && !n_flush;
    e_in_ready  = !n_flush && (!m_ent_v || issue);
    if (n_stats_clr) begin m_stall_cnt = 0; m_fwd_cnt = 0; end
    else begin
      if (e_stall) m_stall_cnt++;
      if (issue)   m_fwd_cnt += nf;
    end
    if (n_flush) begin
      if (m_x_v && !consumed) void'(q.pop_back());
      m_x_v = 0; m_ent_v = 0;
    end else begin
      if (issue) begin q.push_back(o); m_x_v = 1; end
      else if (consumed) m_x_v = 0;
      if (n_in_valid && e_in_ready) begin
        m_ent_v = 1;
        m_ent.a = n_src_addr; m_ent.rf = n_src_data; m_ent.dst = n_dst;
        m_ent.wr = n_wr; m_ent.pl = n_pl;
      end else if (issue) m_ent_v = 0;
    end
    #1;
  endtask

  // Scoreboard monitor: per-cycle flags plus every completed output handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      out_t o;
      chk("out_valid", bus.out_valid, e_out_valid);
      chk("stall", bus.stall, e_stall);
      chk("in_ready", bus.in_ready, e_in_ready);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("sb_unexpected_out", 1, 0);
        else begin
          o = q.pop_front();
          chk("out_src_data", bus.out_src_data, o.d);
          chk("out_meta", {bus.out_dst_addr, bus.out_wr_en, bus.out_payload}, {o.dst, o.wr, o.pl});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); n_src_addr = '0; n_src_data = '0; n_dst = '0; n_wr = 0; n_pl = '0;
    apply();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_out_regs", {bus.out_src_data, bus.out_dst_addr, bus.out_wr_en, bus.out_payload}, 0);
    #9 rst_n = 1'b1;
    mon_en = 1;

    // no hazard
    offer(3, 4, 'h11, 'h22); step();
    idle(); step();
    idle(); step();
    chk("nohaz_valid", bus.out_valid, 1);
    chk("nohaz_data", bus.out_src_data, {32'h22, 32'h11});
    step();

    // priority: stage0 beats stage2
    offer(3, 5, 'h1, 'h2); step();
    idle(); n_stg_wr = 3'b101; n_stg_addr[0] = 3; n_stg_addr[2] = 3;
    n_stg_data[0] = 'hAA; n_stg_data[2] = 'hCC; step();
    idle(); step();
    chk("prio_src0", bus.out_src_data[0], 'hAA);
    offer(3, 5, 'h1, 'h2); step();
    idle(); n_stg_wr = 3'b101; n_stg_addr[0] = 3; n_stg_addr[2] = 3;
    n_stg_data[0] = 'hAA; n_stg_data[2] = 'hCC; n_stg_ok = 3'b100; step();
    chk("prio_pend_stall", bus.stall, 1);
    chk("prio_pend_in_ready", bus.in_ready, 0);
    chk("prio_pend_out_valid", bus.out_valid, 0);
    step();
    n_stg_ok = 3'b111; n_stg_data[0] = 'hBB; step();
    idle(); step();
    chk("prio_release", bus.out_src_data[0], 'hBB);

    // load-use
    idle(); n_stats_clr = 1; step();
    offer(1, 4, 'h10, 'h20); n_stats_clr = 0; step();
    idle(); n_stg_wr = 3'b001; n_stg_addr[0] = 4; n_stg_ok = 3'b000; step();
    chk("lu_stall1", bus.stall, 1);
    step();
    chk("lu_stall2", bus.stall, 1);
    n_stg_ok = 3'b111; n_stg_data[0] = 'h55; step();
    chk("lu_go", bus.stall, 0);
    idle(); step();
    chk("lu_valid", bus.out_valid, 1);
    chk("lu_src", bus.out_src_data, {32'h55, 32'h10});
    step();
    chk("lu_one_pulse", bus.out_valid, 0);
`ifdef DX_BYPASS_STATS_EN
    chk("st_lu_stall", stall_cycles, 2);
    chk("st_lu_fwd", fwd_count, 1);
    n_stats_clr = 1; step(); n_stats_clr = 0; step();
    chk("st_clr", {stall_cycles, fwd_count}, 0);
`endif

    // r0 and backpressure
    offer(0, 2, 'h77, 'h33); step();
    idle(); n_stg_wr = 3'b001; n_stg_addr[0] = 0; n_stg_data[0] = 'hFF; n_out_ready = 0; step();
    idle(); n_out_ready = 0; offer(6, 7, 'h1, 'h2); step();
    chk("r0_data", bus.out_src_data, {32'h33, 32'h0});
    idle(); n_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_hold", bus.out_src_data, {32'h33, 32'h0});
      chk("bp_full_in_ready", bus.in_ready, 0);
    end
    idle(); step(); step(); step();

    // flush while stalled with out_valid
    offer(1, 2, 'h5, 'h6); step();
    offer(9, 10, 'h7, 'h8); step();
    idle(); n_out_ready = 0; n_stg_wr = 3'b001; n_stg_addr[0] = 9; n_stg_ok = 3'b000; step();
    chk("fl_pre_stall", bus.stall, 1);
    chk("fl_pre_valid", bus.out_valid, 1);
    n_flush = 1; step();
    n_flush = 0; n_out_ready = 1; step();
    chk("fl_out_empty", bus.out_valid, 0);
    chk("fl_entry_empty", {bus.stall, bus.in_ready}, 2'b01);

    // async reset mid-stall
    idle(); offer(1, 2, 'h5, 'h6); step();
    idle(); n_stg_wr = 3'b001; n_stg_addr[0] = 1; n_stg_ok = 3'b000; step();
    chk("ar_pre_stall", bus.stall, 1);
    mon_en = 0; #1 rst_n = 1'b0; #1;
    chk("ar_now", {bus.out_valid, bus.stall, bus.in_ready}, 3'b001);
    m_ent_v = 0; m_x_v = 0; q.delete(); m_stall_cnt = 0; m_fwd_cnt = 0;
    idle(); apply();
    @(negedge clk); rst_n = 1'b1; #1 mon_en = 1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      n_in_valid  = ($urandom_range(0, 9) < 7);
      n_src_addr[0] = RW'($urandom_range(0, 7)); n_src_addr[1] = RW'($urandom_range(0, 7));
      n_src_data[0] = $urandom; n_src_data[1] = $urandom;
      n_dst = RW'($urandom_range(0, 31)); n_wr = 1'($urandom_range(0, 1)); n_pl = {$urandom, $urandom};
      for (int k = 0; k < NF; k++) begin
        n_stg_wr[k]   = 1'($urandom_range(0, 1));
        n_stg_addr[k] = RW'($urandom_range(0, 7));
        n_stg_data[k] = $urandom;
        n_stg_ok[k]   = ($urandom_range(0, 3) != 0);
      end
      n_out_ready = ($urandom_range(0, 3) != 0);
      n_flush     = ($urandom_range(0, 49) == 0);
`ifdef DX_BYPASS_STATS_EN
      n_stats_clr = ($urandom_range(0, 199) == 0);
`endif
      step();
    end
    idle(); for (int i = 0; i < 5; i++) step();
    chk("sb_drained", q.size(), 0);
`ifdef DX_BYPASS_STATS_EN
    chk("st_rand_stall", stall_cycles, m_stall_cnt);
    chk("st_rand_fwd", fwd_count, m_fwd_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
